// File: rtl/stream_upsize_pkg.sv
// Shared types and helpers for the stream width upsizer.
package stream_upsize_pkg;

    // Upper bound on lanes supported by the mask helper.
    localparam int MAX_LANES     = 64;
    // Lane count of the default configuration.
    localparam int DEFAULT_RATIO = 4;

    // Per-lane keep mask for the default lane count.
    typedef logic [DEFAULT_RATIO-1:0] keep_t;
    // Wide mask container returned by lane_mask; callers size-cast it.
    typedef logic [MAX_LANES-1:0]     lane_mask_t;

    // Bits needed to index n items. Never returns 0, so a one-lane index is still one bit wide.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // n contiguous ones starting at bit 0.
    function automatic lane_mask_t lane_mask(input int n);
        lane_mask_t m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/stream_upsize_out_reg.sv
// Wide output register of the upsizer: holds a word until the consumer takes it.
// load has priority over clear so that a word can be replaced in the cycle it is read.
module stream_upsize_out_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [KEEP_WIDTH-1:0] load_keep,
    input  logic                  load_last,
    output logic [DATA_WIDTH-1:0] data,
    output logic [KEEP_WIDTH-1:0] keep,
    output logic                  last,
    output logic                  valid
);

    logic [DATA_WIDTH-1:0] data_reg;
    logic [KEEP_WIDTH-1:0] keep_reg;
    logic                  last_reg;
    logic                  valid_reg;

    // Capture a closed word, or drop valid after a read; otherwise hold everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg  <= '0;
            keep_reg  <= '0;
            last_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= load_data;
            keep_reg  <= load_keep;
            last_reg  <= load_last;
            valid_reg <= 1'b1;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end
    end

    assign data  = data_reg;
    assign keep  = keep_reg;
    assign last  = last_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/stream_upsize_acc.sv
// Full-throughput stream upsizer: packs T_DATA_RATIO narrow beats into one wide word.
// An accumulator fills the next word while the output register holds the previous one.
// Partial words are emitted on s_last_i, on flush_i, and, when STREAM_UPSIZE_TIMEOUT_EN
// is defined, after TIMEOUT_CYCLES idle cycles with a partial word pending.
module stream_upsize_acc
    import stream_upsize_pkg::*;
#(
    parameter int T_DATA_WIDTH   = 8,
    parameter int T_DATA_RATIO   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [T_DATA_WIDTH-1:0]              s_data_i,
    input  logic                                 s_last_i,
    input  logic                                 s_valid_i,
    output logic                                 s_ready_o,
    input  logic                                 flush_i,
    output logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] m_data_o,
    output logic [T_DATA_RATIO-1:0]              m_keep_o,
    output logic                                 m_last_o,
    output logic                                 m_valid_o,
    input  logic                                 m_ready_i
);

    localparam int                PTR_W     = clog2_min1(T_DATA_RATIO);
    localparam logic [PTR_W-1:0]  LAST_LANE = PTR_W'(T_DATA_RATIO - 1);

    generate
        if (T_DATA_RATIO < 2 || T_DATA_RATIO > MAX_LANES) begin : g_bad_ratio
            $error("stream_upsize_acc: T_DATA_RATIO must be in 2..%0d", MAX_LANES);
        end
        if (T_DATA_WIDTH < 1) begin : g_bad_width
            $error("stream_upsize_acc: T_DATA_WIDTH must be >= 1");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("stream_upsize_acc: TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    logic [PTR_W-1:0]                      ptr_reg;
    logic [T_DATA_RATIO-1:0]               acc_keep_reg;
    logic [T_DATA_RATIO-1:0]               lane_wr;
    logic [T_DATA_RATIO-1:0]               keep_next;
    logic [T_DATA_WIDTH*T_DATA_RATIO-1:0]  data_next;
    logic                                  last_next;
    logic                                  out_free;
    logic                                  at_last_lane;
    logic                                  ptr_nonzero;
    logic                                  wr;
    logic                                  flush_req;
    logic                                  timeout_hit;
    logic                                  close;
    logic                                  out_clear;

    assign at_last_lane = (ptr_reg == LAST_LANE);
    assign ptr_nonzero  = (ptr_reg != '0);
    assign out_free     = !m_valid_o || m_ready_i;

    // Beats that do not close a word never need the output register, so they may
    // enter while it is stalled; closing beats wait until it can take the word.
    assign s_ready_o = out_free || (!at_last_lane && !s_last_i);
    assign wr        = s_valid_i && s_ready_o;

    assign flush_req = flush_i || timeout_hit;
    // A flush with nothing pending and no beat arriving is dropped: no empty words.
    assign close     = (wr && (at_last_lane || s_last_i)) ||
                       (flush_req && out_free && (ptr_nonzero || wr));
    assign last_next = wr && s_last_i;
    // Replacing the word in the read cycle is handled by load priority in the out reg.
    assign out_clear = m_valid_o && m_ready_i;

    // Lanes already filled plus the lane being written this cycle.
    assign keep_next = acc_keep_reg | lane_wr;

    genvar gi;
    generate
        for (gi = 0; gi < T_DATA_RATIO; gi++) begin : g_lane
            logic [T_DATA_WIDTH-1:0] lane_reg;
            logic [T_DATA_WIDTH-1:0] lane_value;

            assign lane_wr[gi] = wr && (ptr_reg == PTR_W'(gi));

            // Bypass the incoming beat so a closing beat lands in the word it closes.
            always_comb begin
                lane_value = lane_reg;
                if (lane_wr[gi]) begin
                    lane_value = s_data_i;
                end
            end

            // Unfilled lanes may hold stale beats from an earlier word; zero them.
            assign data_next[gi*T_DATA_WIDTH +: T_DATA_WIDTH] = keep_next[gi] ? lane_value : '0;

            // Store the beat addressed to this lane.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= '0;
                end else if (lane_wr[gi]) begin
                    lane_reg <= s_data_i;
                end
            end
        end
    endgenerate

    // Advance the lane pointer on each beat and rewind it whenever a word closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg      <= '0;
            acc_keep_reg <= '0;
        end else if (close) begin
            ptr_reg      <= '0;
            acc_keep_reg <= '0;
        end else if (wr) begin
            ptr_reg      <= ptr_reg + 1'b1;
            acc_keep_reg <= T_DATA_RATIO'(lane_mask(int'(ptr_reg) + 1));
        end
    end

`ifdef STREAM_UPSIZE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idle_cnt_reg;

    // Fires on the TIMEOUT_CYCLES-th idle cycle and stays up while the flush is held back.
    assign timeout_hit = ptr_nonzero && !wr && (idle_cnt_reg >= CNT_W'(TIMEOUT_CYCLES - 1));

    // Count idle cycles with a partial word pending; saturate so a stalled flush stays requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_reg <= '0;
        end else if (wr || close) begin
            idle_cnt_reg <= '0;
        end else if (ptr_nonzero && idle_cnt_reg != CNT_W'(TIMEOUT_CYCLES)) begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    stream_upsize_out_reg #(
        .DATA_WIDTH (T_DATA_WIDTH * T_DATA_RATIO),
        .KEEP_WIDTH (T_DATA_RATIO)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (close),
        .clear     (out_clear),
        .load_data (data_next),
        .load_keep (keep_next),
        .load_last (last_next),
        .data      (m_data_o),
        .keep      (m_keep_o),
        .last      (m_last_o),
        .valid     (m_valid_o)
    );

endmodule

// File: tb/tb_stream_upsize_acc.sv
// Directed bench for stream_upsize_acc with a transaction-level packing model.
module tb_stream_upsize_acc;
    import stream_upsize_pkg::*;

    localparam int W  = 8;
    localparam int R  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   s_data;
    logic           s_last;
    logic           s_valid;
    logic           s_ready;
    logic           flush;
    logic [W*R-1:0] m_data;
    logic [R-1:0]   m_keep;
    logic           m_last;
    logic           m_valid;
    logic           m_ready;

    always #5 clk = ~clk;

    stream_upsize_acc #(
        .T_DATA_WIDTH   (W),
        .T_DATA_RATIO   (R),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .flush_i   (flush),
        .m_data_o  (m_data),
        .m_keep_o  (m_keep),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready)
    );

    int checks = 0;
    int errors = 0;

    // Model: beats collected for the word in progress, plus the word on offer.
    int             fill;
    logic [W-1:0]   pend [R];
    logic           exp_valid;
    logic [W*R-1:0] exp_data;
    keep_t          exp_keep;
    logic           exp_last;
    bit             exp_zero;
    int             idle;
    logic           sready_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        fill      = 0;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_keep  = '0;
        exp_last  = 1'b0;
        exp_zero  = 1'b1;
        idle      = 0;
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, advance the model at the rising edge.
    task automatic step(input logic sv, input logic [W-1:0] sd, input logic sl,
                        input logic fl, input logic mr);
        logic out_free, ready_exp, wr, cl, fire;
        int   n;
        s_valid = sv;
        s_data  = sd;
        s_last  = sl;
        flush   = fl;
        m_ready = mr;
        out_free  = !exp_valid || mr;
        ready_exp = out_free || (fill != R - 1 && !sl);
        @(negedge clk);
        sready_seen = s_ready;
        check("s_ready", s_ready, ready_exp);
        check("m_valid", m_valid, exp_valid);
        if (exp_valid || exp_zero) begin
            check("m_data", m_data, exp_data);
            check("m_keep", m_keep, exp_keep);
            check("m_last", m_last, exp_last);
        end
        @(posedge clk);
        wr   = sv && ready_exp;
        fire = 1'b0;
`ifdef STREAM_UPSIZE_TIMEOUT_EN
        if (fill != 0 && !wr) begin
            idle++;
            fire = (idle >= TO);
        end
`endif
        n  = fill + (wr ? 1 : 0);
        cl = (wr && (fill == R - 1 || sl)) || ((fl || fire) && out_free && n != 0);
        if (exp_valid && mr) begin
            $display("word read data=%h keep=%b last=%b", exp_data, exp_keep, exp_last);
        end
        if (wr) begin
            pend[fill] = sd;
        end
        if (cl) begin
            exp_data = '0;
            for (int i = 0; i < R; i++) begin
                exp_keep[i] = (i < n);
                if (i < n) begin
                    exp_data[i*W +: W] = pend[i];
                end
            end
            exp_last  = wr && sl;
            exp_valid = 1'b1;
            exp_zero  = 1'b0;
            fill      = 0;
            idle      = 0;
        end else begin
            if (wr) begin
                fill = n;
                idle = 0;
            end
            if (exp_valid && mr) begin
                exp_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle_step(input logic mr);
        step(1'b0, '0, 1'b0, 1'b0, mr);
    endtask

    task automatic expect_word(input string name, input logic [W*R-1:0] d,
                               input logic [R-1:0] k, input logic l);
        check({name, "_valid"}, m_valid, 1'b1);
        check({name, "_data"}, m_data, d);
        check({name, "_keep"}, m_keep, k);
        check({name, "_last"}, m_last, l);
    endtask

    int first_valid;

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        model_reset();
        idle_step(1'b0);
        idle_step(1'b0);
        check("reset_valid", m_valid, 1'b0);
        check("reset_keep", m_keep, '0);
        rst = 1'b0;

        // 1: two full words at full rate, s_ready never drops.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, W'((i + 1) * 8'h11), (i == 7), 1'b0, 1'b1);
            check("t1_sready", sready_seen, 1'b1);
            if (i == 3) expect_word("t1_w0", 32'h44332211, 4'b1111, 1'b0);
            if (i == 7) expect_word("t1_w1", 32'h88776655, 4'b1111, 1'b1);
        end
        idle_step(1'b1);
        check("t1_drained", m_valid, 1'b0);

        // 2: three-beat packet, then a one-beat packet starting at lane 0.
        step(1'b1, 8'hA0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hB0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hC0, 1'b1, 1'b0, 1'b1);
        expect_word("t2_w0", 32'h00C0B0A0, 4'b0111, 1'b1);
        step(1'b1, 8'hD0, 1'b1, 1'b0, 1'b1);
        expect_word("t2_lane0", 32'h000000D0, 4'b0001, 1'b1);
        idle_step(1'b1);

        // 3: output stalled; three beats enter, the closing one waits, then swap without a bubble.
        for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        expect_word("t3_pend", 32'h04030201, 4'b1111, 1'b0);
        for (int i = 5; i <= 7; i++) begin
            step(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
            check("t3_accept", sready_seen, 1'b1);
        end
        step(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
        check("t3_stall", sready_seen, 1'b0);
        step(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
        expect_word("t3_hold", 32'h04030201, 4'b1111, 1'b0);
        step(1'b1, 8'h08, 1'b0, 1'b0, 1'b1);
        check("t3_release", sready_seen, 1'b1);
        expect_word("t3_swap", 32'h08070605, 4'b1111, 1'b0);
        idle_step(1'b1);

        // 4: explicit flush of a partial word; flush with nothing pending emits nothing.
        step(1'b1, 8'h21, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        expect_word("t4_flush", 32'h00002221, 4'b0011, 1'b0);
        idle_step(1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("t4_noempty", m_valid, 1'b0);
        idle_step(1'b1);
        check("t4_noempty2", m_valid, 1'b0);

        // Flush held back while the output is stalled.
        for (int i = 1; i <= 4; i++) step(1'b1, W'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h35, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        expect_word("t4_held", 32'h34333231, 4'b1111, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        expect_word("t4_late", 32'h00000035, 4'b0001, 1'b0);
        idle_step(1'b1);

        // Flush together with a non-closing beat includes that beat.
        step(1'b1, 8'h41, 1'b0, 1'b1, 1'b1);
        expect_word("t4_wrflush", 32'h00000041, 4'b0001, 1'b0);
        idle_step(1'b1);

        // 5: asynchronous reset with a word pending and ptr=2.
        for (int i = 1; i <= 6; i++) step(1'b1, W'(8'h50 + i), 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("t5_valid", m_valid, 1'b0);
        check("t5_data", m_data, '0);
        check("t5_keep", m_keep, '0);
        check("t5_last", m_last, 1'b0);
        @(posedge clk);
        #1;
        idle_step(1'b1);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) step(1'b1, W'(8'h60 + i), 1'b0, 1'b0, 1'b1);
        expect_word("t5_resume", 32'h64636261, 4'b1111, 1'b0);
        idle_step(1'b1);

        // 6: one beat then a long idle stretch.
        step(1'b1, 8'h71, 1'b0, 1'b0, 1'b1);
        first_valid = -1;
        for (int i = 1; i <= 100; i++) begin
            idle_step(1'b1);
            if (first_valid < 0 && m_valid) begin
                first_valid = i;
                expect_word("t6_word", 32'h00000071, 4'b0001, 1'b0);
            end
        end
`ifdef STREAM_UPSIZE_TIMEOUT_EN
        check("t6_timeout_cycle", first_valid, 16);
`else
        check("t6_no_output", first_valid, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
